// File: rtl/pmem_if.sv
// Line-granular physical-memory bus between the cache hierarchy (master)
// and a memory responder (slave).
interface pmem_if;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp, proto_err
    );

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp, proto_err
    );
endinterface

// File: rtl/pmem_line_responder.sv
// Fixed-latency 256-bit line store answering pmem_* reads and writes.
// Optional sticky bus-protocol checker enabled by PMEM_PROTOCOL_CHECK_EN.
module pmem_line_responder #(
    parameter int LINE_IDX_W = 6,
    parameter int READ_LAT   = 8,
    parameter int WRITE_LAT  = 8
) (
    input logic   clk,
    input logic   rst,
    pmem_if.slave bus
);
    localparam logic [7:0] RD_LOAD = 8'(READ_LAT - 1);
    localparam logic [7:0] WR_LOAD = 8'(WRITE_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_next;
    logic [7:0]            count;
    logic                  op_is_read;
    logic [255:0]          hold_q;
    logic [255:0]          rdata_q;
    logic [255:0]          store [2**LINE_IDX_W];
    logic [LINE_IDX_W-1:0] req_idx;
    logic                  accept;
    logic                  accept_wr;
    logic                  accept_rd;
    logic [7:0]            load_val;

    assign req_idx = bus.pmem_address[5 +: LINE_IDX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Write has priority over read; a latency of 1 skips BUSY entirely.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_val   = bus.pmem_write ? WR_LOAD : RD_LOAD;
        case (state)
            IDLE: begin
                if (bus.pmem_write || bus.pmem_read) begin
                    accept     = 1'b1;
                    state_next = (load_val == 8'd0) ? RESP : BUSY;
                end
            end
            BUSY:    if (count <= 8'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept_wr = accept && bus.pmem_write;
    assign accept_rd = accept && !bus.pmem_write;

    always_ff @(posedge clk) begin
        if (accept_wr) store[req_idx] <= bus.pmem_wdata;
    end

    // Read data is sampled at acceptance and exposed only when entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 8'd0;
            op_is_read <= 1'b0;
            hold_q     <= '0;
            rdata_q    <= '0;
        end else if (accept) begin
            count      <= load_val;
            op_is_read <= accept_rd;
            if (accept_rd) begin
                hold_q <= store[req_idx];
                if (load_val == 8'd0) rdata_q <= store[req_idx];
            end
        end else if (state == BUSY) begin
            count <= count - 8'd1;
            if (count <= 8'd1 && op_is_read) rdata_q <= hold_q;
        end
    end

    assign bus.pmem_resp  = (state == RESP);
    assign bus.pmem_rdata = rdata_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [26:0]  cap_addr;
    logic [255:0] cap_wdata;
    logic         err_q;
    logic         req_dropped;

    assign req_dropped = op_is_read ? !bus.pmem_read : !bus.pmem_write;

    // Observation only: nothing here feeds back into the functional path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            cap_addr  <= bus.pmem_address[31:5];
            cap_wdata <= bus.pmem_wdata;
            if (bus.pmem_read && bus.pmem_write) err_q <= 1'b1;
        end else if (state == BUSY) begin
            if (req_dropped
                || (bus.pmem_address[31:5] != cap_addr)
                || (!op_is_read && (bus.pmem_wdata != cap_wdata)))
                err_q <= 1'b1;
        end
    end

    assign bus.proto_err = err_q;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench: an 8-cycle-latency responder driven from a vector table,
// plus a 1-cycle-latency instance for back-to-back and aliasing sequences.
module tb_pmem_line_responder;
`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pmem_if bus8 ();
    pmem_if bus1 ();

    pmem_line_responder #(.LINE_IDX_W(6), .READ_LAT(8), .WRITE_LAT(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave)
    );
    pmem_line_responder #(.LINE_IDX_W(6), .READ_LAT(1), .WRITE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic applyStimulus(input int which, input logic wr, input logic rd,
                                 input logic [31:0] addr, input logic [255:0] wd);
        if (which == 8) begin
            bus8.pmem_write = wr; bus8.pmem_read = rd;
            bus8.pmem_address = addr; bus8.pmem_wdata = wd;
        end else begin
            bus1.pmem_write = wr; bus1.pmem_read = rd;
            bus1.pmem_address = addr; bus1.pmem_wdata = wd;
        end
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_resp(input int which);
        return (which == 8) ? bus8.pmem_resp : bus1.pmem_resp;
    endfunction

    function automatic logic [255:0] get_rdata(input int which);
        return (which == 8) ? bus8.pmem_rdata : bus1.pmem_rdata;
    endfunction

    function automatic logic get_err(input int which);
        return (which == 8) ? bus8.proto_err : bus1.proto_err;
    endfunction

    // Called 1 time unit after a rising edge; response must appear exactly lat cycles later.
    task automatic run_txn(input int which, input int lat, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [255:0] wd,
                           input logic [255:0] exp_rd, input string name);
        applyStimulus(which, wr, rd, addr, wd);
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("%s_resp_c%0d", name, k), 256'(get_resp(which)),
                        256'(k == lat));
            if (k == lat) begin
                checkOutput({name, "_rdata"}, get_rdata(which), exp_rd);
                applyStimulus(which, 1'b0, 1'b0, 32'h0, '0);
            end
        end
        checkOutput({name, "_rdata_held"}, get_rdata(which), exp_rd);
    endtask

    initial begin
        logic [255:0] pat_a5, pat_3c, pat_11, pat_77, pat_c3, pat_5a;
        pat_a5 = {32{8'hA5}};
        pat_3c = {32{8'h3C}};
        pat_11 = {32{8'h11}};
        pat_77 = {32{8'h77}};
        pat_c3 = {32{8'hC3}};
        pat_5a = {32{8'h5A}};

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, pat_a5, '0,     1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_005F, '0,     pat_a5, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, pat_3c, pat_a5, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0080, '0,     pat_3c, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0040, '0,     pat_a5, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h1000_0040, pat_11, pat_a5, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0040, '0,     pat_11, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_00C0, pat_77, pat_11, CHK};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_00C0, '0,     pat_77, CHK};

        applyStimulus(8, 1'b0, 1'b0, 32'h0, '0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_resp8",  256'(bus8.pmem_resp), '0);
        checkOutput("reset_rdata8", bus8.pmem_rdata, '0);
        checkOutput("reset_err8",   256'(bus8.proto_err), '0);
        checkOutput("reset_resp1",  256'(bus1.pmem_resp), '0);
        checkOutput("reset_rdata1", bus1.pmem_rdata, '0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(8, 8, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_err", i), 256'(bus8.proto_err),
                        256'(vecs[i].exp_err));
        end

        // Back-to-back write then read at latency 1, through an aliasing address.
        run_txn(1, 1, 1'b1, 1'b0, 32'h0000_0040, pat_c3, '0, "l1_pre_wr");
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0800, pat_5a);
        @(posedge clk); #1;
        checkOutput("b2b_wr_resp_c1", 256'(bus1.pmem_resp), 256'(1));
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_0800, '0);
        @(posedge clk); #1;
        checkOutput("b2b_gap_c2", 256'(bus1.pmem_resp), '0);
        @(posedge clk); #1;
        checkOutput("b2b_rd_resp_c3", 256'(bus1.pmem_resp), 256'(1));
        checkOutput("b2b_rd_data", bus1.pmem_rdata, pat_5a);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, '0);
        @(posedge clk); #1;
        checkOutput("b2b_rd_resp_c4", 256'(bus1.pmem_resp), '0);
        run_txn(1, 1, 1'b0, 1'b1, 32'h0000_0000, '0, pat_5a, "l1_alias_rd");
        run_txn(1, 1, 1'b0, 1'b1, 32'h0000_0040, '0, pat_c3, "l1_line40_rd");
        checkOutput("l1_err", 256'(bus1.proto_err), '0);

        // Reset in cycle 3 of an 8-cycle read aborts it without a response.
        applyStimulus(8, 1'b0, 1'b1, 32'h0000_0080, '0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort_resp_c%0d", k), 256'(bus8.pmem_resp), '0);
        end
        rst = 1'b1;
        applyStimulus(8, 1'b0, 1'b0, 32'h0, '0);
        #1;
        checkOutput("abort_rst_resp",  256'(bus8.pmem_resp), '0);
        checkOutput("abort_rst_rdata", bus8.pmem_rdata, '0);
        checkOutput("abort_rst_err",   256'(bus8.proto_err), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort_quiet_c%0d", k), 256'(bus8.pmem_resp), '0);
        end
        run_txn(8, 8, 1'b0, 1'b1, 32'h0000_0080, '0, pat_3c, "post_rst_rd");

        // Address change while busy: sticky error, function unaffected.
        applyStimulus(8, 1'b0, 1'b1, 32'h0000_0080, '0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("perr_resp_c%0d", k), 256'(bus8.pmem_resp), 256'(k == 8));
            if (k == 3) begin
                checkOutput("perr_before", 256'(bus8.proto_err), '0);
                bus8.pmem_address = 32'h0000_0100;
            end
            if (k == 4) checkOutput("perr_after", 256'(bus8.proto_err), 256'(CHK));
            if (k == 8) begin
                checkOutput("perr_rdata", bus8.pmem_rdata, pat_3c);
                applyStimulus(8, 1'b0, 1'b0, 32'h0, '0);
            end
        end
        run_txn(8, 8, 1'b0, 1'b1, 32'h0000_0040, '0, pat_11, "perr_clean_rd");
        checkOutput("perr_sticky", 256'(get_err(8)), 256'(CHK));
        rst = 1'b1;
        #1;
        checkOutput("perr_cleared", 256'(get_err(8)), '0);
        checkOutput("final_rdata_rst", get_rdata(8), '0);
        checkOutput("final_resp_rst", 256'(get_resp(8)), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
